cp0_exc_ctrl: RTL and testbench
===============================

CP0_EXC_CTRL -- requirements
Module: cp0_exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, default 32'h0000_0020, PC loaded on exception/interrupt entry.
REQ-002 clk  in  1  sole clock, all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-004 exc_req_i  in  1  synchronous exception reported by the commit stage.
REQ-005 exc_code_i  in  5  ExcCode for exc_req_i.
REQ-006 commit_vld_i  in  1  a valid instruction is at commit this cycle; interrupts are sampled only then.
REQ-007 commit_pc_i  in  32  PC of the committing/faulting instruction.
REQ-008 commit_bd_i  in  1  committing instruction is in a branch delay slot.
REQ-009 eret_i  in  1  ERET at commit.
REQ-010 status_i, cause_i, epc_i  in  32 each  current CP0 Status, Cause, EPC values.
REQ-011 cp0_we_o  out  1  write strobe to the CP0 write port.
REQ-012 cp0_waddr_o  out  5  write address (12 Status, 13 Cause, 14 EPC).
REQ-013 cp0_data_o  out  32  write data.
REQ-014 stall_o  out  1  pipeline hold while the sequence runs.
REQ-015 flush_o  out  1  one-cycle pipeline flush with redirect.
REQ-016 new_pc_o  out  32  redirect target, valid when flush_o=1.

Function
REQ-017 States: IDLE, WR_EPC, WR_CAUSE, WR_STATUS, ERET_ST, REDIRECT; all outputs registered.
REQ-018 pend = cause_i[15:8] & status_i[15:8]; int_take = commit_vld_i & (pend!=0) & status_i[0] & ~status_i[1].
REQ-019 In IDLE, priority: exc_req_i > int_take > eret_i; the lower-priority request is dropped that cycle.
REQ-020 On acceptance (edge T), capture PC=commit_pc_i, BD=commit_bd_i, CODE=exc_code_i (5'd0 for interrupt), EXL0=status_i[1], EPCSAVE=epc_i.
REQ-021 Exception/interrupt path: IDLE -> WR_EPC -> WR_CAUSE -> WR_STATUS -> REDIRECT -> IDLE; if EXL0=1, WR_EPC is skipped (IDLE -> WR_CAUSE).
REQ-022 WR_EPC: cp0_we_o=1, waddr=14, data=PC.
REQ-023 WR_CAUSE: we=1, waddr=13, data=cause_i with [6:2]=CODE and [31]=BD (bit 31 left as cause_i[31] if EXL0=1).
REQ-024 WR_STATUS: we=1, waddr=12, data=status_i | 32'h2.
REQ-025 ERET path: IDLE -> ERET_ST -> REDIRECT -> IDLE; ERET_ST writes waddr=12, data=status_i & ~32'h2.
REQ-026 REDIRECT: flush_o=1, cp0_we_o=0, new_pc_o=EXC_VECTOR (exception/interrupt) or EPCSAVE (ERET).
REQ-027 Latency: exception accepted at T -> writes at T+1..T+3, flush at T+4; EXL0=1 -> flush at T+3; ERET -> flush at T+2.
REQ-028 stall_o=1 in every non-IDLE state, 0 in IDLE; all request inputs ignored outside IDLE.
REQ-029 cp0_we_o=0, cp0_waddr_o=0, cp0_data_o=0 in IDLE and REDIRECT; flush_o exactly one cycle per sequence.
REQ-030 Back-to-back: a request present in the first IDLE cycle after REDIRECT is accepted normally.

Reset
REQ-031 rst=0 forces state IDLE and all outputs plus captured registers to 0 immediately, regardless of clk.
REQ-032 Reset mid-sequence abandons the sequence; no further CP0 writes or flush after rst returns to 1.

Verification
REQ-033 exc_req_i=1, code=5'd12, PC=32'h100, BD=0, status=32'h1000_0001 -> T+1 (14,32'h100), T+2 Cause[6:2]=12, T+3 (12,32'h1000_0003), T+4 flush_o=1, new_pc_o=32'h20.
REQ-034 cause_i[10]=1, status_i=32'h0000_0401, commit_vld_i=1 -> interrupt entry, Cause[6:2]=0; same with status_i[0]=0 -> no action.
REQ-035 eret_i=1, epc_i=32'h200, status_i=32'h3 -> T+1 write (12,32'h1), T+2 flush_o=1, new_pc_o=32'h200.
REQ-036 exc_req_i and eret_i same cycle -> exception path only; exc_req_i with status_i[1]=1 -> no EPC write, flush at T+3.
REQ-037 rst=0 asserted during WR_CAUSE -> outputs 0 at once, stall_o=0, no flush afterwards.

Source files
------------

// File: rtl/cp0_exc_ctrl.sv
// ============================================================================
// Module   : cp0_exc_ctrl
// Brief    : CP0 exception / interrupt / ERET sequencer. Writes EPC, Cause and
//            Status through the CP0 write port, then flushes and redirects.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cp0_exc_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_req_i,
    input  logic [4:0]  exc_code_i,
    input  logic        commit_vld_i,
    input  logic [31:0] commit_pc_i,
    input  logic        commit_bd_i,
    input  logic        eret_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    output logic        cp0_we_o,
    output logic [4:0]  cp0_waddr_o,
    output logic [31:0] cp0_data_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WR_EPC    = 3'd1;
    localparam logic [2:0] S_WR_CAUSE  = 3'd2;
    localparam logic [2:0] S_WR_STATUS = 3'd3;
    localparam logic [2:0] S_ERET      = 3'd4;
    localparam logic [2:0] S_REDIRECT  = 3'd5;

    localparam logic [4:0] C_ADDR_STATUS = 5'd12;
    localparam logic [4:0] C_ADDR_CAUSE  = 5'd13;
    localparam logic [4:0] C_ADDR_EPC    = 5'd14;

    logic [2:0]  state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic        bd_q,      bd_d;
    logic [4:0]  code_q,    code_d;
    logic        exl0_q,    exl0_d;
    logic [31:0] epcsave_q, epcsave_d;
    logic        eret_q,    eret_d;

    logic        we_q,      we_d;
    logic [4:0]  waddr_q,   waddr_d;
    logic [31:0] data_q,    data_d;
    logic        stall_q,   stall_d;
    logic        flush_q,   flush_d;
    logic [31:0] new_pc_q,  new_pc_d;

    logic [7:0]  w_pend;
    logic        w_int_take;

    assign w_pend     = cause_i[15:8] & status_i[15:8];
    assign w_int_take = commit_vld_i & (w_pend != 8'd0) & status_i[0] & ~status_i[1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= 32'd0;
            bd_q      <= 1'b0;
            code_q    <= 5'd0;
            exl0_q    <= 1'b0;
            epcsave_q <= 32'd0;
            eret_q    <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= 5'd0;
            data_q    <= 32'd0;
            stall_q   <= 1'b0;
            flush_q   <= 1'b0;
            new_pc_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            bd_q      <= bd_d;
            code_q    <= code_d;
            exl0_q    <= exl0_d;
            epcsave_q <= epcsave_d;
            eret_q    <= eret_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            data_q    <= data_d;
            stall_q   <= stall_d;
            flush_q   <= flush_d;
            new_pc_q  <= new_pc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        bd_d      = bd_q;
        code_d    = code_q;
        exl0_d    = exl0_q;
        epcsave_d = epcsave_q;
        eret_d    = eret_q;
        case (state_q)
            S_IDLE: begin
                if (exc_req_i || w_int_take || eret_i) begin
                    pc_d      = commit_pc_i;
                    bd_d      = commit_bd_i;
                    exl0_d    = status_i[1];
                    epcsave_d = epc_i;
                    code_d    = exc_req_i ? exc_code_i : 5'd0;
                    eret_d    = ~exc_req_i & ~w_int_take;
                    if (exc_req_i || w_int_take) begin
                        // A nested exception keeps the original EPC.
                        state_d = status_i[1] ? S_WR_CAUSE : S_WR_EPC;
                    end else begin
                        state_d = S_ERET;
                    end
                end
            end
            S_WR_EPC:    state_d = S_WR_CAUSE;
            S_WR_CAUSE:  state_d = S_WR_STATUS;
            S_WR_STATUS: state_d = S_REDIRECT;
            S_ERET:      state_d = S_REDIRECT;
            S_REDIRECT:  state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so the flops line up with state_q.
    always_comb begin
        we_d     = 1'b0;
        waddr_d  = 5'd0;
        data_d   = 32'd0;
        flush_d  = 1'b0;
        new_pc_d = 32'd0;
        stall_d  = (state_d != S_IDLE);
        case (state_d)
            S_WR_EPC: begin
                we_d    = 1'b1;
                waddr_d = C_ADDR_EPC;
                data_d  = pc_d;
            end
            S_WR_CAUSE: begin
                we_d        = 1'b1;
                waddr_d     = C_ADDR_CAUSE;
                data_d      = cause_i;
                data_d[6:2] = code_d;
                if (!exl0_d) begin
                    data_d[31] = bd_d;
                end
            end
            S_WR_STATUS: begin
                we_d    = 1'b1;
                waddr_d = C_ADDR_STATUS;
                data_d  = status_i | 32'h0000_0002;
            end
            S_ERET: begin
                we_d    = 1'b1;
                waddr_d = C_ADDR_STATUS;
                data_d  = status_i & ~32'h0000_0002;
            end
            S_REDIRECT: begin
                flush_d  = 1'b1;
                new_pc_d = eret_d ? epcsave_d : EXC_VECTOR;
            end
            default: ;
        endcase
    end

    assign cp0_we_o    = we_q;
    assign cp0_waddr_o = waddr_q;
    assign cp0_data_o  = data_q;
    assign stall_o     = stall_q;
    assign flush_o     = flush_q;
    assign new_pc_o    = new_pc_q;

endmodule

`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
// ============================================================================
// Module   : tb_cp0_exc_ctrl
// Brief    : Scoreboard bench for cp0_exc_ctrl; directed sequences push the
//            expected CP0 writes / flushes, a monitor pops and compares them.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exc_req_i = 1'b0;
    logic [4:0]  exc_code_i = 5'd0;
    logic        commit_vld_i = 1'b0;
    logic [31:0] commit_pc_i = 32'd0;
    logic        commit_bd_i = 1'b0;
    logic        eret_i = 1'b0;
    logic [31:0] status_i = 32'd0;
    logic [31:0] cause_i = 32'd0;
    logic [31:0] epc_i = 32'd0;
    logic        cp0_we_o;
    logic [4:0]  cp0_waddr_o;
    logic [31:0] cp0_data_o;
    logic        stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;

    cp0_exc_ctrl #(.EXC_VECTOR(32'h0000_0020)) dut (
        .clk          (clk),
        .rst          (rst),
        .exc_req_i    (exc_req_i),
        .exc_code_i   (exc_code_i),
        .commit_vld_i (commit_vld_i),
        .commit_pc_i  (commit_pc_i),
        .commit_bd_i  (commit_bd_i),
        .eret_i       (eret_i),
        .status_i     (status_i),
        .cause_i      (cause_i),
        .epc_i        (epc_i),
        .cp0_we_o     (cp0_we_o),
        .cp0_waddr_o  (cp0_waddr_o),
        .cp0_data_o   (cp0_data_o),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          flush;
        logic [4:0]  addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t expq[$];
    exp_t e;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_w(input int c, input logic [4:0] a, input logic [31:0] d);
        exp_t x;
        x.flush = 1'b0; x.addr = a; x.data = d; x.cyc = c;
        expq.push_back(x);
    endtask

    task automatic push_f(input int c, input logic [31:0] pc);
        exp_t x;
        x.flush = 1'b1; x.addr = 5'd0; x.data = pc; x.cyc = c;
        expq.push_back(x);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Monitor: every write strobe or flush must match the head of the queue.
    always @(negedge clk) begin
        if (rst && (cp0_we_o || flush_o)) begin
            n_cmp++;
            if (expq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_out: cyc %0d we %b addr %0d data %h flush %b pc %h",
                         cyc, cp0_we_o, cp0_waddr_o, cp0_data_o, flush_o, new_pc_o);
            end else begin
                e = expq.pop_front();
                if (e.flush) begin
                    if (!flush_o || cp0_we_o || new_pc_o !== e.data || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL flush: got flush %b we %b pc %h cyc %0d expected pc %h cyc %0d",
                                 flush_o, cp0_we_o, new_pc_o, cyc, e.data, e.cyc);
                    end
                end else begin
                    if (flush_o || cp0_waddr_o !== e.addr || cp0_data_o !== e.data || cyc != e.cyc) begin
                        n_bad++;
                        $display("FAIL write: got flush %b addr %0d data %h cyc %0d expected addr %0d data %h cyc %0d",
                                 flush_o, cp0_waddr_o, cp0_data_o, cyc, e.addr, e.data, e.cyc);
                    end
                end
            end
        end
    end

    task automatic drive(input logic exc, input logic [4:0] code, input logic vld,
                         input logic [31:0] pc, input logic bd, input logic er,
                         input logic [31:0] st, input logic [31:0] ca,
                         input logic [31:0] ep, output int c);
        @(negedge clk);
        exc_req_i = exc; exc_code_i = code; commit_vld_i = vld;
        commit_pc_i = pc; commit_bd_i = bd; eret_i = er;
        status_i = st; cause_i = ca; epc_i = ep;
        c = cyc;
    endtask

    task automatic release_req();
        @(negedge clk);
        exc_req_i = 1'b0; commit_vld_i = 1'b0; eret_i = 1'b0;
    endtask

    task automatic drain(input string name);
        repeat (8) @(negedge clk);
        chk(name, expq.size(), 0);
        chk({name, "_stall"}, {31'd0, stall_o}, 0);
    endtask

    initial begin
        int c;
        #1;
        chk("rst_we",    {31'd0, cp0_we_o}, 0);
        chk("rst_stall", {31'd0, stall_o},  0);
        chk("rst_flush", {31'd0, flush_o},  0);
        chk("rst_data",  cp0_data_o,        0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Plain synchronous exception
        drive(1, 5'd12, 1, 32'h100, 0, 0, 32'h1000_0001, 32'h0, 32'h0, c);
        push_w(c+1, 5'd14, 32'h0000_0100);
        push_w(c+2, 5'd13, 32'h0000_0030);
        push_w(c+3, 5'd12, 32'h1000_0003);
        push_f(c+4, 32'h20);
        release_req();
        chk("exc_stall", {31'd0, stall_o}, 1);
        drain("exc_drain");

        // Interrupt: Cause ExcCode forced to 0, BD goes to bit 31
        drive(0, 5'd8, 1, 32'h300, 1, 0, 32'h0000_0401, 32'h0000_047C, 32'h0, c);
        push_w(c+1, 5'd14, 32'h0000_0300);
        push_w(c+2, 5'd13, 32'h8000_0400);
        push_w(c+3, 5'd12, 32'h0000_0403);
        push_f(c+4, 32'h20);
        release_req();
        drain("int_drain");

        // Interrupt masked by IE=0, then not at a commit slot: no action
        drive(0, 5'd0, 1, 32'h300, 0, 0, 32'h0000_0400, 32'h0000_0400, 32'h0, c);
        release_req();
        chk("int_ie0_stall", {31'd0, stall_o}, 0);
        drive(0, 5'd0, 0, 32'h300, 0, 0, 32'h0000_0401, 32'h0000_0400, 32'h0, c);
        release_req();
        chk("int_novld_stall", {31'd0, stall_o}, 0);
        drain("noact_drain");

        // ERET
        drive(0, 5'd0, 1, 32'h0, 0, 1, 32'h0000_0003, 32'h0, 32'h200, c);
        push_w(c+1, 5'd12, 32'h0000_0001);
        push_f(c+2, 32'h200);
        release_req();
        drain("eret_drain");

        // Exception beats ERET in the same cycle
        drive(1, 5'd4, 1, 32'h400, 1, 1, 32'h0000_0001, 32'h0, 32'h999, c);
        push_w(c+1, 5'd14, 32'h0000_0400);
        push_w(c+2, 5'd13, 32'h8000_0010);
        push_w(c+3, 5'd12, 32'h0000_0003);
        push_f(c+4, 32'h20);
        release_req();
        drain("prio_drain");

        // Nested exception (EXL=1): no EPC write, Cause[31] untouched
        drive(1, 5'd10, 1, 32'h500, 1, 0, 32'h0000_0003, 32'h0, 32'h0, c);
        push_w(c+1, 5'd13, 32'h0000_0028);
        push_w(c+2, 5'd12, 32'h0000_0003);
        push_f(c+3, 32'h20);
        release_req();
        drain("exl_drain");

        // ERET followed by an exception held high; only the first IDLE cycle accepts it
        drive(0, 5'd0, 1, 32'h0, 0, 1, 32'h0000_0003, 32'h0, 32'h200, c);
        push_w(c+1, 5'd12, 32'h0000_0001);
        push_f(c+2, 32'h200);
        push_w(c+4, 5'd13, 32'h0000_0004);
        push_w(c+5, 5'd12, 32'h0000_0003);
        push_f(c+6, 32'h20);
        @(negedge clk);
        eret_i = 1'b0; exc_req_i = 1'b1; exc_code_i = 5'd1;
        commit_pc_i = 32'h600; commit_bd_i = 1'b0;
        repeat (3) @(negedge clk);
        exc_req_i = 1'b0; commit_vld_i = 1'b0;
        drain("b2b_drain");

        // Reset during WR_CAUSE
        drive(1, 5'd3, 1, 32'h700, 0, 0, 32'h0000_0001, 32'h0, 32'h0, c);
        push_w(c+1, 5'd14, 32'h0000_0700);
        release_req();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mrst_we",    {31'd0, cp0_we_o}, 0);
        chk("mrst_addr",  {27'd0, cp0_waddr_o}, 0);
        chk("mrst_data",  cp0_data_o, 0);
        chk("mrst_stall", {31'd0, stall_o}, 0);
        chk("mrst_flush", {31'd0, flush_o}, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drain("mrst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
